// File: rtl/awgn_stats_monitor.sv
// awgn_stats_monitor
// Block statistics engine for a two-channel AWGN sample stream. After a start it
// takes 2**N_LOG2 valid sample pairs and accumulates, per channel, the signed sum,
// the sum of squares, the peak magnitude and the count of samples whose magnitude
// reaches TAIL. Arithmetic is a two-stage pipeline:
//   stage 1: sign extension, |x|, |x|*|x| and the tail compare;
//   stage 2: accumulation.
// A one-cycle done pulse marks the point where the results become final.
module awgn_stats_monitor #(
    parameter int          W      = 16,
    parameter int          N_LOG2 = 10,
    parameter int unsigned TAIL   = 8192
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       v,
    input  logic signed [W-1:0]        x0,
    input  logic signed [W-1:0]        x1,
    output logic                       busy,
    output logic                       done,
    output logic                       res_valid,
    output logic signed [W+N_LOG2-1:0] sum0,
    output logic signed [W+N_LOG2-1:0] sum1,
    output logic [2*W+N_LOG2-1:0]      sq0,
    output logic [2*W+N_LOG2-1:0]      sq1,
    output logic [W-1:0]               pk0,
    output logic [W-1:0]               pk1,
    output logic [N_LOG2:0]            tail0,
    output logic [N_LOG2:0]            tail1
);

    // Accumulator widths are chosen so that N copies of the most negative
    // sample cannot overflow.
    localparam int SW = W + N_LOG2;
    localparam int QW = 2 * W + N_LOG2;
    localparam int TW = N_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [N_LOG2-1:0]  r_cnt;
    logic               r_s1_valid;
    logic               r_done;
    logic               r_res_valid;
    logic               w_accept;
    logic               w_clear;
    logic               w_last;
    logic               w_busy;
    logic               w_done_next;

    logic signed [W-1:0] w_x     [2];
    logic [SW-1:0]       w_sum_o [2];
    logic [QW-1:0]       w_sq_o  [2];
    logic [W-1:0]        w_pk_o  [2];
    logic [TW-1:0]       w_tail_o[2];

    // Abort always wins over start, so an aborted start leaves everything untouched.
    assign w_clear  = (r_state == S_IDLE) && start && !abort;
    assign w_accept = (r_state == S_ACCUM) && v && !abort;
    assign w_last   = (r_cnt == {N_LOG2{1'b1}});

    assign w_x[0] = x0;
    assign w_x[1] = x1;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state. DRAIN stays until the last pair has left stage 1.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) w_state_next = S_ACCUM;
            end
            S_ACCUM: begin
                if (abort)                 w_state_next = S_IDLE;
                else if (v && w_last)      w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort || !r_s1_valid)  w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs. done is raised as DRAIN leaves with the last pair already summed.
    always_comb begin
        w_busy      = (r_state != S_IDLE);
        w_done_next = (r_state == S_DRAIN) && !r_s1_valid && !abort;
    end

    // Pair counter, stage-1 valid flag, done pulse and result-valid flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_s1_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_done     <= w_done_next;
            if (w_clear)          r_cnt <= '0;
            else if (w_accept)    r_cnt <= r_cnt + 1'b1;
            if (w_clear)          r_res_valid <= 1'b0;
            else if (w_done_next) r_res_valid <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [W-1:0]   w_mag;
            logic [2*W-1:0] w_sq;
            logic           w_tail;
            logic [SW-1:0]  r_s1_sx;
            logic [W-1:0]   r_s1_mag;
            logic [2*W-1:0] r_s1_sq;
            logic           r_s1_tail;
            logic [SW-1:0]  r_sum;
            logic [QW-1:0]  r_sq;
            logic [W-1:0]   r_pk;
            logic [TW-1:0]  r_tail;

            // The negation of the most negative sample wraps back to the same bit
            // pattern, which read as unsigned is exactly 2**(W-1).
            assign w_mag  = w_x[gi][W-1] ? $unsigned(-w_x[gi]) : $unsigned(w_x[gi]);
            assign w_sq   = {{W{1'b0}}, w_mag} * {{W{1'b0}}, w_mag};
            assign w_tail = ({{(32-W){1'b0}}, w_mag} >= TAIL);

            // Stage 1: capture the per-sample terms of each accepted pair
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_s1_sx   <= '0;
                    r_s1_mag  <= '0;
                    r_s1_sq   <= '0;
                    r_s1_tail <= 1'b0;
                end else if (w_accept) begin
                    r_s1_sx   <= {{N_LOG2{w_x[gi][W-1]}}, w_x[gi]};
                    r_s1_mag  <= w_mag;
                    r_s1_sq   <= w_sq;
                    r_s1_tail <= w_tail;
                end
            end

            // Stage 2: fold stage-1 terms into the block accumulators
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sum  <= '0;
                    r_sq   <= '0;
                    r_pk   <= '0;
                    r_tail <= '0;
                end else if (w_clear) begin
                    r_sum  <= '0;
                    r_sq   <= '0;
                    r_pk   <= '0;
                    r_tail <= '0;
                end else if (r_s1_valid) begin
                    r_sum  <= r_sum + r_s1_sx;
                    r_sq   <= r_sq + {{N_LOG2{1'b0}}, r_s1_sq};
                    r_tail <= r_tail + {{N_LOG2{1'b0}}, r_s1_tail};
                    if (r_s1_mag > r_pk) r_pk <= r_s1_mag;
                end
            end

            assign w_sum_o[gi]  = r_sum;
            assign w_sq_o[gi]   = r_sq;
            assign w_pk_o[gi]   = r_pk;
            assign w_tail_o[gi] = r_tail;
        end
    endgenerate

    assign busy      = w_busy;
    assign done      = r_done;
    assign res_valid = r_res_valid;
    assign sum0      = $signed(w_sum_o[0]);
    assign sum1      = $signed(w_sum_o[1]);
    assign sq0       = w_sq_o[0];
    assign sq1       = w_sq_o[1];
    assign pk0       = w_pk_o[0];
    assign pk1       = w_pk_o[1];
    assign tail0     = w_tail_o[0];
    assign tail1     = w_tail_o[1];

endmodule
